// File: rtl/conv_seq_ctrl.sv
// Conversion sequencer for the ADC/CIC/FIR chain: channel mask, settle with CIC
// clear, filter flush with output gating, and single-shot bursts with a done pulse.
module conv_seq_ctrl #(
    parameter int NUM_CH   = 4,
    parameter int SETTLE_W = 8,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                conv_en_i,
    input  logic                mode_i,
    input  logic [NUM_CH-1:0]   ch_mask_i,
    input  logic [SETTLE_W-1:0] settle_cycles_i,
    input  logic [SETTLE_W-1:0] flush_cycles_i,
    input  logic [CNT_W-1:0]    burst_len_i,
    input  logic                sample_valid_i,
    output logic [NUM_CH-1:0]   adc_en_o,
    output logic                cic_en_o,
    output logic                cic_clr_o,
    output logic                fir_en_o,
    output logic                data_gate_o,
    output logic                busy_o,
    output logic                done_o,
    output logic [CNT_W-1:0]    sample_cnt_o
);

    typedef enum logic [2:0] {IDLE, SETTLE, FLUSH, RUN, DONE} state_e;

    state_e              state_q, state_d;
    logic [SETTLE_W-1:0] cnt_q, cnt_d;
    logic [SETTLE_W-1:0] flush_q, flush_d;
    logic [NUM_CH-1:0]   mask_q, mask_d;
    logic                mode_q, mode_d;
    logic [CNT_W-1:0]    blen_q, blen_d;
    logic [CNT_W-1:0]    sample_cnt_q, sample_cnt_d;
    logic [NUM_CH-1:0]   adc_en_q;
    logic                cic_en_q, cic_clr_q, fir_en_q, data_gate_q, busy_q, done_q;

    logic [CNT_W-1:0] blen_eff;
    logic [CNT_W-1:0] cnt_inc;
    logic             active_d;

    assign blen_eff = (blen_q == '0) ? CNT_W'(1) : blen_q;
    assign cnt_inc  = (&sample_cnt_q) ? sample_cnt_q : sample_cnt_q + CNT_W'(1);

    always_comb begin
        // NOTE: every variable gets a default before the case so no latch is inferred.
        state_d      = state_q;
        cnt_d        = cnt_q;
        flush_d      = flush_q;
        mask_d       = mask_q;
        mode_d       = mode_q;
        blen_d       = blen_q;
        sample_cnt_d = sample_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (conv_en_i && (ch_mask_i != '0)) begin
                    mask_d       = ch_mask_i;
                    mode_d       = mode_i;
                    blen_d       = burst_len_i;
                    flush_d      = flush_cycles_i;
                    sample_cnt_d = '0;
                    cnt_d        = (settle_cycles_i == '0) ? '0 : settle_cycles_i - SETTLE_W'(1);
                    state_d      = SETTLE;
                end
            end
            SETTLE: begin
                if (!conv_en_i) begin
                    state_d = IDLE;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - SETTLE_W'(1);
                end else if (flush_q != '0) begin
                    cnt_d   = flush_q - SETTLE_W'(1);
                    state_d = FLUSH;
                end else begin
                    state_d = RUN;
                end
            end
            FLUSH: begin
                if (!conv_en_i)          state_d = IDLE;
                else if (cnt_q != '0)    cnt_d   = cnt_q - SETTLE_W'(1);
                else                     state_d = RUN;
            end
            RUN: begin
                if (sample_valid_i) sample_cnt_d = cnt_inc;
                // The final burst sample outranks a simultaneous conv_en drop.
                if (mode_q && sample_valid_i && (cnt_inc >= blen_eff)) state_d = DONE;
                else if (!conv_en_i)                                   state_d = IDLE;
            end
            DONE: begin
                if (!conv_en_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign active_d = (state_d == SETTLE) || (state_d == FLUSH) || (state_d == RUN);

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            flush_q      <= '0;
            mask_q       <= '0;
            mode_q       <= 1'b0;
            blen_q       <= '0;
            sample_cnt_q <= '0;
            adc_en_q     <= '0;
            cic_en_q     <= 1'b0;
            cic_clr_q    <= 1'b0;
            fir_en_q     <= 1'b0;
            data_gate_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            flush_q      <= flush_d;
            mask_q       <= mask_d;
            mode_q       <= mode_d;
            blen_q       <= blen_d;
            sample_cnt_q <= sample_cnt_d;
            adc_en_q     <= active_d ? mask_d : '0;
            cic_clr_q    <= (state_d == SETTLE);
            cic_en_q     <= (state_d == FLUSH) || (state_d == RUN);
            fir_en_q     <= (state_d == FLUSH) || (state_d == RUN);
            data_gate_q  <= (state_d == RUN);
            busy_q       <= active_d;
            done_q       <= (state_q == RUN) && (state_d == DONE);
        end
    end

    assign adc_en_o     = adc_en_q;
    assign cic_en_o     = cic_en_q;
    assign cic_clr_o    = cic_clr_q;
    assign fir_en_o     = fir_en_q;
    assign data_gate_o  = data_gate_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign sample_cnt_o = sample_cnt_q;

endmodule
